axi4_lite_addr_route_stage: RTL and testbench

Registered, flow-controlled address decode stage for one AXI4-Lite address channel (AW or AR) inside the interconnect. Decodes each incoming address against a parametrised base/mask map with fixed lowest-index priority, registers the one-hot and encoded select, and tracks outstanding transactions. A new address is held back if it targets a different slave than the one with responses still pending, which keeps responses in order. One instance sits per address channel, between the master port and the crossbar mux/demux.

---
 rtl/axi4_lite_addr_route_stage.sv | 156 +++++++++++++++
 tb/tb_axi4_lite_addr_route_stage.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_addr_route_stage.sv
// AXI4-Lite address decode/route stage with in-order outstanding tracking.
// Optional: AXI4_LITE_DECERR_EN gives unmapped addresses their own target.
module axi4_lite_addr_route_stage #(
  parameter int ADDR_WIDTH      = 32,
  parameter int SLAVE_NUM       = 4,
  parameter logic [SLAVE_NUM-1:0][ADDR_WIDTH-1:0] SLAVE_BASE_ADDR = '0,
  parameter logic [SLAVE_NUM-1:0][ADDR_WIDTH-1:0] SLAVE_ADDR_MASK = '0,
  parameter int MAX_OUTSTANDING = 4,
  localparam int IW = $clog2(SLAVE_NUM),
  localparam int CW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [SLAVE_NUM-1:0]  out_sel,
  output logic [IW-1:0]         out_sel_idx,
  output logic                  out_decerr,
  input  logic                  rsp_done,
  output logic [CW-1:0]         outstanding
);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [SLAVE_NUM-1:0]  sel;
    logic [IW-1:0]         idx;
    logic                  decerr;
  } hold_t;

  typedef enum logic {
    IDLE,
    BUSY
  } trk_state_t;

  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);

  logic [SLAVE_NUM-1:0] dec_match;
  logic [IW-1:0]        dec_idx;
  logic [SLAVE_NUM-1:0] dec_sel;
  logic                 dec_decerr;

  hold_t      hold_q;
  logic       hold_full;
  trk_state_t state_q;
  trk_state_t state_d;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic [IW-1:0] cur_idx;
  logic       same_tgt;
  logic       at_max;
  logic       launch;
  logic       load;
  logic       rsp_eff;

  // Per-slave match vector
  always_comb begin
    dec_match = '0;
    for (int i = 0; i < SLAVE_NUM; i++) begin
      dec_match[i] =
        (in_addr & SLAVE_ADDR_MASK[i]) == SLAVE_BASE_ADDR[i];
    end
  end

  // Lowest matching index wins
  always_comb begin
    dec_idx = '0;
    for (int i = SLAVE_NUM - 1; i >= 0; i--) begin
      if (dec_match[i]) begin
        dec_idx = IW'(i);
      end
    end
  end

`ifdef AXI4_LITE_DECERR_EN
  logic cur_decerr;
  logic dec_hit;

  assign dec_hit    = |dec_match;
  assign dec_decerr = !dec_hit;
  assign dec_sel    = dec_hit ? (SLAVE_NUM'(1) << dec_idx) : '0;
  assign same_tgt   = (hold_q.idx == cur_idx) &&
                      (hold_q.decerr == cur_decerr);
`else
  assign dec_decerr = 1'b0;
  assign dec_sel    = SLAVE_NUM'(1) << dec_idx;
  assign same_tgt   = hold_q.idx == cur_idx;
`endif

  assign at_max    = count_q == CNT_MAX;
  assign out_valid = hold_full &&
                     (state_q == IDLE || (same_tgt && !at_max));
  assign launch    = out_valid && out_ready;
  assign in_ready  = !hold_full || launch;
  assign load      = in_valid && in_ready;
  assign rsp_eff   = rsp_done && (state_q == BUSY);

  assign out_addr    = hold_q.addr;
  assign out_sel     = hold_q.sel;
  assign out_sel_idx = hold_q.idx;
  assign out_decerr  = hold_q.decerr;
  assign outstanding = count_q;

  // Holding register: refill on accept, empty on launch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_full <= 1'b0;
      hold_q    <= '0;
    end else if (load) begin
      hold_full     <= 1'b1;
      hold_q.addr   <= in_addr;
      hold_q.sel    <= dec_sel;
      hold_q.idx    <= dec_idx;
      hold_q.decerr <= dec_decerr;
    end else if (launch) begin
      hold_full <= 1'b0;
    end
  end

  // Tracker next state; a stray rsp_done at zero is dropped
  always_comb begin
    count_d = count_q;
    state_d = state_q;
    unique case (1'b1)
      launch && !rsp_eff: count_d = count_q + CW'(1);
      rsp_eff && !launch: count_d = count_q - CW'(1);
      default: ;
    endcase
    state_d = (count_d == '0) ? IDLE : BUSY;
  end

  // Tracker state register and current target
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      cur_idx <= '0;
`ifdef AXI4_LITE_DECERR_EN
      cur_decerr <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (launch) begin
        cur_idx <= hold_q.idx;
`ifdef AXI4_LITE_DECERR_EN
        cur_decerr <= hold_q.decerr;
`endif
      end
    end
  end

endmodule

// File: tb/tb_axi4_lite_addr_route_stage.sv
// Scoreboard bench for axi4_lite_addr_route_stage.
// Directed addresses with hand-computed routes.
module tb_axi4_lite_addr_route_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_addr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_addr;
  logic [3:0]  out_sel;
  logic [1:0]  out_sel_idx;
  logic        out_decerr;
  logic        rsp_done;
  logic [2:0]  outstanding;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [1:0]  idx;
    logic        dec;
  } exp_t;

  exp_t q[$];
  exp_t e;

  always #5 clk = ~clk;

  axi4_lite_addr_route_stage #(
    .ADDR_WIDTH(32),
    .SLAVE_NUM(4),
    .SLAVE_BASE_ADDR({32'h2000_0000, 32'h2000_0000,
                      32'h1000_0000, 32'h0000_0000}),
    .SLAVE_ADDR_MASK({32'hFF00_0000, 32'hF000_0000,
                      32'hF000_0000, 32'hF000_0000}),
    .MAX_OUTSTANDING(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_addr(in_addr),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_addr(out_addr),
    .out_sel(out_sel),
    .out_sel_idx(out_sel_idx),
    .out_decerr(out_decerr),
    .rsp_done(rsp_done),
    .outstanding(outstanding)
  );

  task automatic chk(input string n, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rsp(input int n);
    rsp_done = 1'b1;
    cyc(n);
    rsp_done = 1'b0;
  endtask

  task automatic send(input logic [31:0] a, input logic [3:0] s,
                      input logic [1:0] i, input logic d);
    int w;
    w = 0;
    in_valid = 1'b1;
    in_addr  = a;
    q.push_back('{a, s, i, d});
    while (!in_ready && w < 50) begin
      cyc(1);
      w++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: addr %0h never accepted", a);
    end
    cyc(1);
    in_valid = 1'b0;
  endtask

  task automatic chk_reset(input string n);
    chk({n, "_in_ready"}, in_ready, 1);
    chk({n, "_out_valid"}, out_valid, 0);
    chk({n, "_out_addr"}, out_addr, 0);
    chk({n, "_out_sel"}, out_sel, 0);
    chk({n, "_out_idx"}, out_sel_idx, 0);
    chk({n, "_out_decerr"}, out_decerr, 0);
    chk({n, "_outstanding"}, outstanding, 0);
  endtask

  // Monitor: every launch pops and compares one expected route
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected: addr %0h launched, none expected",
                 out_addr);
      end else begin
        e = q.pop_front();
        if (out_addr !== e.addr || out_sel !== e.sel ||
            out_sel_idx !== e.idx || out_decerr !== e.dec) begin
          fails++;
          $display("FAIL sb_route: got %0h/%b/%0d/%b expected %0h/%b/%0d/%b",
                   out_addr, out_sel, out_sel_idx, out_decerr,
                   e.addr, e.sel, e.idx, e.dec);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_addr   = '0;
    out_ready = 1'b1;
    rsp_done  = 1'b0;
    #2;
    chk_reset("rst_hold");
    #15;
    rst_n = 1'b1;
    cyc(1);
    chk_reset("rst_rel");

    // basic route, one-cycle latency
    send(32'h1000_0040, 4'b0010, 2'd1, 1'b0);
    chk("basic_valid", out_valid, 1);
    cyc(1);
    chk("basic_cnt", outstanding, 1);
    chk("basic_drained", out_valid, 0);
    rsp(1);
    chk("basic_cnt0", outstanding, 0);

    // priority on overlap, stall with out_ready low
    out_ready = 1'b0;
    send(32'h2000_0000, 4'b0100, 2'd2, 1'b0);
    chk("prio_valid", out_valid, 1);
    chk("prio_in_ready", in_ready, 0);
    cyc(2);
    chk("prio_hold_valid", out_valid, 1);
    chk("prio_hold_addr", out_addr, 32'h2000_0000);
    chk("prio_hold_cnt", outstanding, 0);
    out_ready = 1'b1;
    cyc(1);
    chk("prio_cnt", outstanding, 1);
    rsp(1);

    // back-to-back fill to MAX_OUTSTANDING
    send(32'h1000_0100, 4'b0010, 2'd1, 1'b0);
    send(32'h1000_0200, 4'b0010, 2'd1, 1'b0);
    send(32'h1000_0300, 4'b0010, 2'd1, 1'b0);
    send(32'h1000_0400, 4'b0010, 2'd1, 1'b0);
    cyc(1);
    chk("full_cnt4", outstanding, 4);
    send(32'h1000_0500, 4'b0010, 2'd1, 1'b0);
    chk("full_blocked", out_valid, 0);
    chk("full_in_ready", in_ready, 0);
    cyc(1);
    chk("full_blocked2", out_valid, 0);
    rsp(1);
    chk("full_release", out_valid, 1);
    chk("full_cnt3", outstanding, 3);
    cyc(1);
    chk("full_cnt4b", outstanding, 4);
    rsp(4);
    chk("full_drain", outstanding, 0);

    // target switch waits for count to reach zero
    send(32'h1000_0100, 4'b0010, 2'd1, 1'b0);
    send(32'h1000_0200, 4'b0010, 2'd1, 1'b0);
    send(32'h0000_0080, 4'b0001, 2'd0, 1'b0);
    chk("sw_cnt2", outstanding, 2);
    chk("sw_blocked", out_valid, 0);
    cyc(1);
    chk("sw_blocked2", out_valid, 0);
    rsp_done = 1'b1;
    cyc(1);
    chk("sw_blocked_cnt1", out_valid, 0);
    cyc(1);
    rsp_done = 1'b0;
    chk("sw_valid", out_valid, 1);
    chk("sw_idx", out_sel_idx, 0);
    chk("sw_cnt0", outstanding, 0);
    cyc(1);
    chk("sw_cnt1", outstanding, 1);
    rsp(1);

    // unmapped address
`ifdef AXI4_LITE_DECERR_EN
    send(32'h5000_0000, 4'b0000, 2'd0, 1'b1);
    chk("unmap_decerr", out_decerr, 1);
`else
    send(32'h5000_0000, 4'b0001, 2'd0, 1'b0);
    chk("unmap_decerr", out_decerr, 0);
`endif
    cyc(1);
    chk("unmap_cnt", outstanding, 1);
    rsp(1);
    chk("unmap_cnt0", outstanding, 0);

    // launch and rsp_done in the same cycle
    send(32'h2100_0000, 4'b0100, 2'd2, 1'b0);
    send(32'h2100_0010, 4'b0100, 2'd2, 1'b0);
    send(32'h2100_0020, 4'b0100, 2'd2, 1'b0);
    chk("both_pre", outstanding, 2);
    rsp(1);
    chk("both_same", outstanding, 2);

    // asynchronous reset mid-burst
    in_valid = 1'b1;
    in_addr  = 32'h2200_0000;
    @(posedge clk);
    #3;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk_reset("rst_async");
    q.delete();
    #2;
    rst_n = 1'b1;
    cyc(1);
    send(32'h0000_0010, 4'b0001, 2'd0, 1'b0);
    cyc(1);
    chk("post_rst_cnt", outstanding, 1);
    rsp(1);
    cyc(2);
    chk("sb_empty", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
